zest_ad7794_resp: RTL and testbench
===================================

Name: zest_ad7794_resp

Overview:
Synthesizable SPI responder that emulates the AD7794 thermometer ADC (U18) at the far end of the carrier's U18 CLK/CS/DIN/SCLK/DOUT_RDY signals.
Used in loopback builds and simulation benches so the carrier-side AD7794 driver can be exercised without the Zest board.
Oversamples the SPI pins in the system clock domain and implements the communications-register protocol, a register file, and DOUT/RDY signalling.

Parameters:
ID_VALUE, 8'h0F, value returned by the ID register (RS=3'd4)
SYNC_STAGES, 2, synchronizer depth for the sclk/cs/din inputs (min 2)

Ports:
clk  input  1  system clock; must be at least 4x SCLK frequency
rst_n  input  1  synchronous active-low reset
spi_sclk  input  1  SPI clock, idle high (CPOL=1)
spi_cs  input  1  chip select, active low
spi_din  input  1  MOSI
spi_dout_rdy  output  1  MISO / RDY (combined pin)
spi_dout_oe  output  1  high while cs is asserted (for tristate emulation)
conv_data  input  24  new conversion result
conv_valid  input  1  single-cycle strobe: load conv_data into the data register
mode_reg  output  16  current mode register
config_reg  output  16  current configuration register
io_reg  output  8  current IO register
reg_wr  output  1  single-cycle pulse when any register write completes
reg_wr_addr  output  3  RS address of the completed write

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low. All inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk and cs.
- Reset values:
  - mode 16'h000A, config 16'h0710, io 8'h00, offset 24'h800000, full-scale 24'h500000, data 24'h000000, status 8'h88 (/RDY=1).
  - spi_dout_rdy=1, spi_dout_oe=0, reg_wr=0, reg_wr_addr=0, FSM=IDLE.
- Bit timing: DIN is sampled on the detected sclk rising edge. DOUT is updated on the detected sclk falling edge. MSB first. Latency from pin to action is SYNC_STAGES+1 clk.
- FSM states:
  - IDLE: cs high. dout_rdy=1, oe=0. cs falling -> COMM.
  - COMM: shift in 8 bits. While no bits have been shifted yet, dout_rdy = status[7] (/RDY). After the 8th bit:
    - bit7 (WEN)=1 -> ignore the byte, stay in COMM.
    - Else RS=bits[5:3] and R/W=bit6. Length L = 8/16/24 per register: status 8, mode 16, config 16, data 24, ID 8, IO 8, offset 24, full-scale 24.
    - R/W=1 -> READ; R/W=0 -> WRITE. Writes to RS 0 (status), RS 3 (data) and RS 4 (ID) are accepted and discarded: no reg_wr pulse.
  - WRITE: shift in L bits. On the last bit, update the register and pulse reg_wr for 1 cycle with reg_wr_addr=RS. Return to COMM.
  - READ: the shift register is loaded on COMM completion. Output L bits, with the first bit driven immediately at load. After the last rising edge, return to COMM. Completing a data-register read sets status[7]=1.
- status[7]: cleared to 0 on conv_valid. conv_valid in the same cycle as data-read completion: conv_valid wins (status[7]=0, new data stored). A READ in progress keeps its snapshot.
- Serial reset: 32 consecutive DIN=1 sampled while cs is low (in any state) restores all register reset values and enters COMM.
- cs rising mid-frame: abort, discard the partial write, clear bit counters, go to IDLE. Ones-counter is cleared.
- rst_n low mid-transfer: immediate return to reset values on the next clk edge.

Optional Feature:
ZEST_AD7794_CREAD_EN
- Defined:
  - Writing comm byte 8'h5C enters CREAD.
  - In CREAD, each falling edge of status[7] automatically loads the data register for a 24-bit READ, with no command byte; dout_rdy shows /RDY between words.
  - DIN byte 8'h58 received during a CREAD word exits to COMM after that word.
  - cs high preserves CREAD.
- Undefined: 8'h5C is an ordinary single data-register read.

Decomposition:
- Package zest_ad7794_pkg:
  - RS address localparams (RS_STATUS..RS_FULLSCALE)
  - register-length function by RS
  - reset-value constants
  - FSM state enum (IDLE, COMM, WRITE, READ, CREAD)
- Sub-module: spi_edge_sync (synchronizer plus rise/fall detect for sclk and cs, pass-through din).

Test Plan:
- Write 8'h08 then 16'h200A -> reg_wr pulse, reg_wr_addr=3'd1, mode_reg=16'h200A.
- Write 8'h60 (ID read) -> 8 bits out equal 8'h0F.
- conv_valid with conv_data=24'hABCDEF; idle cs low -> dout_rdy=0; comm 8'h58 -> 24 bits 24'hABCDEF, then dout_rdy=1.
- Write 8'h10, 8 of 16 config bits, cs high, new frame read 8'h50 -> config_reg still 16'h0710, no reg_wr.
- After writing io=8'h55, send 32 ones -> io_reg=8'h00, mode_reg=16'h000A; comm byte 8'hFF next -> ignored.
- (CREAD_EN) 8'h5C, three conv_valid strobes 24'h000001/2/3 -> three 24-bit words 1, 2, 3 with no command bytes; send 8'h58 -> back to COMM.

Source files
------------

// File: rtl/zest_ad7794_resp_pkg.sv
// AD7794 responder: RS addresses, register lengths, reset values, FSM states.
// Shared by the responder top and its SPI front end.
package zest_ad7794_pkg;

  localparam logic [2:0] RS_STATUS    = 3'd0;
  localparam logic [2:0] RS_MODE      = 3'd1;
  localparam logic [2:0] RS_CONFIG    = 3'd2;
  localparam logic [2:0] RS_DATA      = 3'd3;
  localparam logic [2:0] RS_ID        = 3'd4;
  localparam logic [2:0] RS_IO        = 3'd5;
  localparam logic [2:0] RS_OFFSET    = 3'd6;
  localparam logic [2:0] RS_FULLSCALE = 3'd7;

  localparam logic [15:0] MODE_RST   = 16'h000A;
  localparam logic [15:0] CONFIG_RST = 16'h0710;
  localparam logic [7:0]  IO_RST     = 8'h00;
  localparam logic [23:0] OFFSET_RST = 24'h800000;
  localparam logic [23:0] FS_RST     = 24'h500000;
  localparam logic [23:0] DATA_RST   = 24'h000000;
  localparam logic [7:0]  STATUS_RST = 8'h88;

  localparam logic [7:0] CMD_CREAD = 8'h5C;
  localparam logic [7:0] CMD_DREAD = 8'h58;

  typedef enum logic [2:0] {
    IDLE,
    COMM,
    WRITE,
    READ,
    CREAD
  } state_t;

  function automatic logic [4:0] reg_len(
    input logic [2:0] rs
  );
    unique case (1'b1)
      (rs == RS_MODE),
      (rs == RS_CONFIG):    reg_len = 5'd16;
      (rs == RS_DATA),
      (rs == RS_OFFSET),
      (rs == RS_FULLSCALE): reg_len = 5'd24;
      default:              reg_len = 5'd8;
    endcase
  endfunction

  // status, data and ID swallow writes silently
  function automatic logic reg_writable(
    input logic [2:0] rs
  );
    reg_writable = !(rs == RS_STATUS ||
                     rs == RS_DATA ||
                     rs == RS_ID);
  endfunction

endpackage

// File: rtl/zest_ad7794_resp_if.sv
// SPI pin bundle between the carrier-side AD7794 driver
// and the responder.
interface zest_ad7794_resp_if;
  logic spi_sclk;
  logic spi_cs;
  logic spi_din;
  logic spi_dout_rdy;
  logic spi_dout_oe;

  modport master (
    output spi_sclk,
    output spi_cs,
    output spi_din,
    input  spi_dout_rdy,
    input  spi_dout_oe
  );

  modport slave (
    input  spi_sclk,
    input  spi_cs,
    input  spi_din,
    output spi_dout_rdy,
    output spi_dout_oe
  );
endinterface

// File: rtl/zest_ad7794_resp_spi_edge_sync.sv
// Synchronizes sclk/cs/din into clk and flags
// sclk and cs edges; din stays aligned with sclk.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs,
  input  logic din,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic cs_s,
  output logic din_s
);

  logic [SYNC_STAGES-1:0] sclk_p;
  logic [SYNC_STAGES-1:0] cs_p;
  logic [SYNC_STAGES-1:0] din_p;
  logic                   sclk_q;
  logic                   cs_q;
  logic                   sclk_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_p <= '1;
      cs_p   <= '1;
      din_p  <= '0;
      sclk_q <= 1'b1;
      cs_q   <= 1'b1;
    end else begin
      sclk_p <= {sclk_p[SYNC_STAGES-2:0], sclk};
      cs_p   <= {cs_p[SYNC_STAGES-2:0], cs};
      din_p  <= {din_p[SYNC_STAGES-2:0], din};
      sclk_q <= sclk_p[SYNC_STAGES-1];
      cs_q   <= cs_p[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_p[SYNC_STAGES-1];
  assign cs_s      = cs_p[SYNC_STAGES-1];
  assign din_s     = din_p[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

endmodule

// File: rtl/zest_ad7794_resp.sv
// AD7794 SPI responder (comm register, register file, DOUT/RDY).
// ZEST_AD7794_CREAD_EN enables continuous-read mode.
module zest_ad7794_resp
  import zest_ad7794_pkg::*;
#(
  parameter logic [7:0] ID_VALUE    = 8'h0F,
  parameter int         SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  zest_ad7794_resp_if.slave  spi,
  input  logic [23:0]        conv_data,
  input  logic               conv_valid,
  output logic [15:0]        mode_reg,
  output logic [15:0]        config_reg,
  output logic [7:0]         io_reg,
  output logic               reg_wr,
  output logic [2:0]         reg_wr_addr
);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic cs_s, din_s;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (spi.spi_sclk),
    .cs       (spi.spi_cs),
    .din      (spi.spi_din),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall),
    .cs_s     (cs_s),
    .din_s    (din_s)
  );

  state_t      state, state_d;
  logic [4:0]  cnt, len, ones;
  logic [2:0]  rs;
  logic [23:0] in_sr, out_sr;
  logic [23:0] offset_q, fs_q, data_q;
  logic [7:0]  status_q;
  logic [23:0] sh, rd_word;
  logic [4:0]  cnt_inc;
  logic [2:0]  rs_new;
  logic        last_bit, byte_end;
  logic        comm_end, wr_end, rd_end;
  logic        cread_load, serial_rst;
  logic        cread_q, cread_cmd, cread_stay;
  logic        dout;

  assign sh         = {in_sr[22:0], din_s};
  assign cnt_inc    = cnt + 5'd1;
  assign rs_new     = sh[5:3];
  assign last_bit   = sclk_rise && (cnt_inc == len);
  assign byte_end   = sclk_rise && (cnt[2:0] == 3'd7);
  assign serial_rst = sclk_rise && !cs_s && din_s &&
                      (ones == 5'd31);

`ifdef ZEST_AD7794_CREAD_EN
  logic exit_q, exit_hit;
  assign exit_hit   = byte_end && (sh[7:0] == CMD_DREAD);
  assign cread_cmd  = (sh[7:0] == CMD_CREAD);
  assign cread_stay = cread_q && !exit_q && !exit_hit;

  always_ff @(posedge clk) begin
    if (!rst_n || serial_rst) begin
      cread_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      if (comm_end && cread_cmd) cread_q <= 1'b1;
      if (rd_end && !cread_stay) cread_q <= 1'b0;
      if (cread_load)
        exit_q <= 1'b0;
      else if (exit_hit && state == READ)
        exit_q <= 1'b1;
    end
  end
`else
  assign cread_q    = 1'b0;
  assign cread_cmd  = 1'b0;
  assign cread_stay = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    comm_end   = 1'b0;
    wr_end     = 1'b0;
    rd_end     = 1'b0;
    cread_load = 1'b0;
    if (serial_rst) begin
      state_d = COMM;
    end else if (cs_rise) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: if (cs_fall)
          state_d = cread_q ? CREAD : COMM;
        COMM: if (byte_end) begin
          comm_end = 1'b1;
          if (!sh[7])
            state_d = cread_cmd ? CREAD :
                      (sh[6] ? READ : WRITE);
        end
        WRITE: if (last_bit) begin
          wr_end  = 1'b1;
          state_d = COMM;
        end
        READ: if (last_bit) begin
          rd_end  = 1'b1;
          state_d = cread_stay ? CREAD : COMM;
        end
        CREAD: if (!status_q[7]) begin
          cread_load = 1'b1;
          state_d    = READ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // read words are left-aligned so bit 23 is always the next out
  always_comb begin
    rd_word = '0;
    unique case (rs_new)
      RS_STATUS: rd_word = {status_q, 16'h0};
      RS_MODE:   rd_word = {mode_reg, 8'h0};
      RS_CONFIG: rd_word = {config_reg, 8'h0};
      RS_DATA:   rd_word = data_q;
      RS_ID:     rd_word = {ID_VALUE, 16'h0};
      RS_IO:     rd_word = {io_reg, 16'h0};
      RS_OFFSET: rd_word = offset_q;
      default:   rd_word = fs_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      len    <= 5'd8;
      rs     <= RS_STATUS;
      in_sr  <= '0;
      out_sr <= '1;
      ones   <= '0;
    end else begin
      if (sclk_rise && !cs_s)
        ones <= din_s ? ones + 5'd1 : 5'd0;
      if (cs_rise || serial_rst) begin
        cnt  <= '0;
        ones <= '0;
      end else if (cread_load) begin
        cnt    <= '0;
        rs     <= RS_DATA;
        len    <= 5'd24;
        out_sr <= data_q;
      end else if (sclk_rise &&
                   (state == COMM || state == WRITE ||
                    state == READ)) begin
        in_sr <= sh;
        cnt   <= (comm_end || wr_end || rd_end) ?
                 5'd0 : cnt_inc;
        if (comm_end) begin
          rs     <= rs_new;
          len    <= reg_len(rs_new);
          out_sr <= rd_word;
        end
      end else if (sclk_fall && state == READ &&
                   cnt != 5'd0) begin
        // first bit was presented at load; shift only after it is taken
        out_sr <= {out_sr[22:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || serial_rst) begin
      mode_reg   <= MODE_RST;
      config_reg <= CONFIG_RST;
      io_reg     <= IO_RST;
      offset_q   <= OFFSET_RST;
      fs_q       <= FS_RST;
      data_q     <= DATA_RST;
      status_q   <= STATUS_RST;
    end else begin
      if (wr_end) begin
        unique case (rs)
          RS_MODE:      mode_reg   <= sh[15:0];
          RS_CONFIG:    config_reg <= sh[15:0];
          RS_IO:        io_reg     <= sh[7:0];
          RS_OFFSET:    offset_q   <= sh;
          RS_FULLSCALE: fs_q       <= sh;
          default:      ;
        endcase
      end
      if (rd_end && rs == RS_DATA) status_q[7] <= 1'b1;
      if (conv_valid) begin
        data_q      <= conv_data;
        status_q[7] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_wr      <= 1'b0;
      reg_wr_addr <= '0;
    end else begin
      reg_wr <= wr_end && reg_writable(rs);
      if (wr_end && reg_writable(rs))
        reg_wr_addr <= rs;
    end
  end

  always_comb begin
    dout = 1'b1;
    unique case (state)
      COMM:    dout = (cnt == 5'd0) ? status_q[7] : 1'b1;
      READ:    dout = out_sr[23];
      CREAD:   dout = status_q[7];
      default: dout = 1'b1;
    endcase
  end

  assign spi.spi_dout_rdy = dout;
  assign spi.spi_dout_oe  = ~cs_s;

endmodule

// File: tb/tb_zest_ad7794_resp.sv
// Directed bench for the AD7794 responder.
// Drives SPI mode 3 at 10 MHz from a 100 MHz clk.
module tb_zest_ad7794_resp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] conv_data = '0;
  logic        conv_valid = 1'b0;
  logic [15:0] mode_reg, config_reg;
  logic [7:0]  io_reg;
  logic        reg_wr;
  logic [2:0]  reg_wr_addr;

  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  logic [2:0]  wr_last = '0;

  zest_ad7794_resp_if bus ();

  zest_ad7794_resp #(
    .ID_VALUE   (8'h0F),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi        (bus),
    .conv_data  (conv_data),
    .conv_valid (conv_valid),
    .mode_reg   (mode_reg),
    .config_reg (config_reg),
    .io_reg     (io_reg),
    .reg_wr     (reg_wr),
    .reg_wr_addr(reg_wr_addr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cnt  = wr_cnt + 1;
      wr_last = reg_wr_addr;
    end
  end

  task automatic xfer(input logic [23:0] tx, input int n,
                      output logic [23:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_sclk = 1'b0;
      bus.spi_din  = tx[i];
      #50;
      rx = {rx[22:0], bus.spi_dout_rdy};
      bus.spi_sclk = 1'b1;
      #50;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs = 1'b0;
    #100;
  endtask

  task automatic cs_high();
    bus.spi_cs = 1'b1;
    #100;
  endtask

  task automatic pulse_conv(input logic [23:0] d);
    @(negedge clk);
    conv_data  = d;
    conv_valid = 1'b1;
    @(negedge clk);
    conv_valid = 1'b0;
    #100;
  endtask

  task automatic test_reset();
    bus.spi_sclk = 1'b1;
    bus.spi_cs   = 1'b1;
    bus.spi_din  = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (mode_reg !== 16'h000A) begin
      errors++;
      $display("FAIL rst_mode got %h want 000a", mode_reg);
    end
    checks++;
    if (config_reg !== 16'h0710) begin
      errors++;
      $display("FAIL rst_config got %h want 0710", config_reg);
    end
    checks++;
    if (io_reg !== 8'h00) begin
      errors++;
      $display("FAIL rst_io got %h want 00", io_reg);
    end
    checks++;
    if (bus.spi_dout_rdy !== 1'b1 || bus.spi_dout_oe !== 1'b0) begin
      errors++;
      $display("FAIL rst_pins got %b%b want 10",
               bus.spi_dout_rdy, bus.spi_dout_oe);
    end
    checks++;
    if (reg_wr !== 1'b0 || reg_wr_addr !== 3'd0) begin
      errors++;
      $display("FAIL rst_wr got %b/%0d want 0/0", reg_wr, reg_wr_addr);
    end
  endtask

  task automatic test_write_mode();
    logic [23:0] rx;
    int          w0;
    cs_low();
    checks++;
    if (bus.spi_dout_oe !== 1'b1 || bus.spi_dout_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cs_low_pins got %b%b want 11",
               bus.spi_dout_oe, bus.spi_dout_rdy);
    end
    w0 = wr_cnt;
    xfer(24'h08, 8, rx);
    xfer(24'h200A, 16, rx);
    #100;
    checks++;
    if (wr_cnt - w0 !== 1 || wr_last !== 3'd1) begin
      errors++;
      $display("FAIL mode_wr got %0d/%0d want 1/1",
               wr_cnt - w0, wr_last);
    end
    checks++;
    if (mode_reg !== 16'h200A) begin
      errors++;
      $display("FAIL mode_val got %h want 200a", mode_reg);
    end
    xfer(24'h48, 8, rx);
    xfer(24'h0, 16, rx);
    checks++;
    if (rx[15:0] !== 16'h200A) begin
      errors++;
      $display("FAIL mode_rd got %h want 200a", rx[15:0]);
    end
  endtask

  task automatic test_id_read();
    logic [23:0] rx;
    xfer(24'h60, 8, rx);
    xfer(24'h0, 8, rx);
    checks++;
    if (rx[7:0] !== 8'h0F) begin
      errors++;
      $display("FAIL id_rd got %h want 0f", rx[7:0]);
    end
  endtask

  task automatic test_data_read();
    logic [23:0] rx;
    pulse_conv(24'hABCDEF);
    checks++;
    if (bus.spi_dout_rdy !== 1'b0) begin
      errors++;
      $display("FAIL rdy_low got %b want 0", bus.spi_dout_rdy);
    end
    xfer(24'h58, 8, rx);
    xfer(24'h0, 24, rx);
    checks++;
    if (rx !== 24'hABCDEF) begin
      errors++;
      $display("FAIL data_rd got %h want abcdef", rx);
    end
    #100;
    checks++;
    if (bus.spi_dout_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_high got %b want 1", bus.spi_dout_rdy);
    end
  endtask

  task automatic test_abort();
    logic [23:0] rx;
    int          w0;
    w0 = wr_cnt;
    xfer(24'h10, 8, rx);
    xfer(24'hA5, 8, rx);
    cs_high();
    cs_low();
    xfer(24'h50, 8, rx);
    xfer(24'h0, 16, rx);
    checks++;
    if (rx[15:0] !== 16'h0710) begin
      errors++;
      $display("FAIL abort_rd got %h want 0710", rx[15:0]);
    end
    checks++;
    if (config_reg !== 16'h0710 || wr_cnt !== w0) begin
      errors++;
      $display("FAIL abort_reg got %h/%0d want 0710/0",
               config_reg, wr_cnt - w0);
    end
  endtask

  task automatic test_discard_writes();
    logic [23:0] rx;
    int          w0;
    w0 = wr_cnt;
    xfer(24'h00, 8, rx);
    xfer(24'h00, 8, rx);
    xfer(24'h20, 8, rx);
    xfer(24'h33, 8, rx);
    xfer(24'h18, 8, rx);
    xfer(24'h123456, 24, rx);
    #100;
    checks++;
    if (wr_cnt !== w0) begin
      errors++;
      $display("FAIL ro_wr got %0d want 0 pulses", wr_cnt - w0);
    end
    xfer(24'h60, 8, rx);
    xfer(24'h0, 8, rx);
    checks++;
    if (rx[7:0] !== 8'h0F) begin
      errors++;
      $display("FAIL id_keep got %h want 0f", rx[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] rx;
    xfer(24'h78, 8, rx);
    xfer(24'h0, 24, rx);
    checks++;
    if (rx !== 24'h500000) begin
      errors++;
      $display("FAIL fs_rst got %h want 500000", rx);
    end
    xfer(24'h30, 8, rx);
    xfer(24'h123456, 24, rx);
    #100;
    checks++;
    if (wr_last !== 3'd6) begin
      errors++;
      $display("FAIL off_addr got %0d want 6", wr_last);
    end
    xfer(24'h70, 8, rx);
    xfer(24'h0, 24, rx);
    checks++;
    if (rx !== 24'h123456) begin
      errors++;
      $display("FAIL off_rd got %h want 123456", rx);
    end
  endtask

  task automatic test_serial_reset();
    logic [23:0] rx;
    int          w0;
    xfer(24'h28, 8, rx);
    xfer(24'h55, 8, rx);
    #100;
    checks++;
    if (io_reg !== 8'h55 || wr_last !== 3'd5) begin
      errors++;
      $display("FAIL io_wr got %h/%0d want 55/5", io_reg, wr_last);
    end
    cs_high();
    cs_low();
    xfer(24'hFFFFFF, 24, rx);
    xfer(24'hFF, 8, rx);
    #100;
    checks++;
    if (io_reg !== 8'h00 || mode_reg !== 16'h000A) begin
      errors++;
      $display("FAIL sreset got %h/%h want 00/000a",
               io_reg, mode_reg);
    end
    w0 = wr_cnt;
    xfer(24'hFF, 8, rx);
    xfer(24'h48, 8, rx);
    xfer(24'h0, 16, rx);
    checks++;
    if (rx[15:0] !== 16'h000A || wr_cnt !== w0) begin
      errors++;
      $display("FAIL wen_ignore got %h/%0d want 000a/0",
               rx[15:0], wr_cnt - w0);
    end
  endtask

`ifdef ZEST_AD7794_CREAD_EN
  task automatic test_cread();
    logic [23:0] rx;
    logic [23:0] tx;
    xfer(24'h5C, 8, rx);
    #100;
    checks++;
    if (bus.spi_dout_rdy !== 1'b1) begin
      errors++;
      $display("FAIL cread_wait got %b want 1", bus.spi_dout_rdy);
    end
    for (int k = 1; k <= 3; k++) begin
      pulse_conv(24'(k));
      tx = (k == 3) ? 24'h000058 : 24'h0;
      xfer(tx, 24, rx);
      checks++;
      if (rx !== 24'(k)) begin
        errors++;
        $display("FAIL cread_word%0d got %h want %h", k, rx, 24'(k));
      end
    end
    #100;
    xfer(24'h60, 8, rx);
    xfer(24'h0, 8, rx);
    checks++;
    if (rx[7:0] !== 8'h0F) begin
      errors++;
      $display("FAIL cread_exit got %h want 0f", rx[7:0]);
    end
  endtask
`else
  task automatic test_cread();
    logic [23:0] rx;
    pulse_conv(24'h000777);
    xfer(24'h5C, 8, rx);
    xfer(24'h0, 24, rx);
    checks++;
    if (rx !== 24'h000777) begin
      errors++;
      $display("FAIL plain_5c got %h want 000777", rx);
    end
    xfer(24'h60, 8, rx);
    xfer(24'h0, 8, rx);
    checks++;
    if (rx[7:0] !== 8'h0F) begin
      errors++;
      $display("FAIL after_5c got %h want 0f", rx[7:0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_mode();
    test_id_read();
    test_data_read();
    test_abort();
    test_discard_writes();
    test_back_to_back();
    test_serial_reset();
    test_cread();
    cs_high();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
